// File: rtl/simd_core_pkg.sv
// Shared SIMD core definitions: scoreboard geometry, FU index map,
// per-slot state record and a popcount helper for the busy counter.
package simd_core_pkg;

  localparam int NUM_FU   = 11;  // functional units == scoreboard slots
  localparam int ADDR_W   = 5;   // vector register address width
  localparam int LAT_W    = 4;   // latency counter width
  localparam int FU_IDX_W = 4;   // width of FU index fields on the bus
  localparam int CNT_W    = 4;   // width of the busy slot count

  // Functional unit index map (slot number == FU index)
  localparam logic [FU_IDX_W-1:0] FU_VALU0 = 4'd0;
  localparam logic [FU_IDX_W-1:0] FU_VALU1 = 4'd1;
  localparam logic [FU_IDX_W-1:0] FU_VMUL0 = 4'd2;
  localparam logic [FU_IDX_W-1:0] FU_VMUL1 = 4'd3;
  localparam logic [FU_IDX_W-1:0] FU_VDIV  = 4'd4;
  localparam logic [FU_IDX_W-1:0] FU_VLD0  = 4'd5;
  localparam logic [FU_IDX_W-1:0] FU_VLD1  = 4'd6;
  localparam logic [FU_IDX_W-1:0] FU_VST   = 4'd7;
  localparam logic [FU_IDX_W-1:0] FU_VRED  = 4'd8;
  localparam logic [FU_IDX_W-1:0] FU_VPERM = 4'd9;
  localparam logic [FU_IDX_W-1:0] FU_VCMP  = 4'd10;

  // One scoreboard entry. cnt==0 on a valid slot means "wait for writeback".
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [ADDR_W-1:0] vdst;
    logic [LAT_W-1:0]  cnt;
  } slot_t;

  // Number of set bits in a slot bitmap
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_FU-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/simd_dest_scoreboard_if.sv
// Issue / writeback / query / status bundle between decode (master)
// and the destination scoreboard (slave).
interface simd_dest_scoreboard_if;
  import simd_core_pkg::*;

  // issue channel
  logic                     issue_valid;
  logic [FU_IDX_W-1:0]      issue_fu;
  logic [ADDR_W-1:0]        issue_vdst;
  logic                     issue_regwrite;
  logic [LAT_W-1:0]         issue_lat;
  logic                     issue_ready;
  // writeback channel
  logic                     wb_valid;
  logic [FU_IDX_W-1:0]      wb_fu;
  // decode source query
  logic [ADDR_W-1:0]        qry_rs;
  logic [ADDR_W-1:0]        qry_rt;
  // published scoreboard state
  logic [NUM_FU*ADDR_W-1:0] fu_vdst_addr;
  logic [NUM_FU-1:0]        fu_busy;
  logic [NUM_FU-1:0]        fu_regwrite;
  logic                     raw_hazard;
  logic [CNT_W-1:0]         busy_cnt;

  modport master (
    output issue_valid, issue_fu, issue_vdst, issue_regwrite, issue_lat,
    output wb_valid, wb_fu, qry_rs, qry_rt,
    input  issue_ready, fu_vdst_addr, fu_busy, fu_regwrite, raw_hazard, busy_cnt
  );

  modport slave (
    input  issue_valid, issue_fu, issue_vdst, issue_regwrite, issue_lat,
    input  wb_valid, wb_fu, qry_rs, qry_rt,
    output issue_ready, fu_vdst_addr, fu_busy, fu_regwrite, raw_hazard, busy_cnt
  );

endinterface

// File: rtl/scoreboard_slot.sv
// One scoreboard entry: loads on issue, counts latency down, and clears
// on expiry (cnt==1) or on writeback. A load always takes priority so a
// same-cycle writeback cannot wipe a freshly issued instruction.
module scoreboard_slot
  import simd_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_regwrite,
  input  logic [ADDR_W-1:0] load_vdst,
  input  logic [LAT_W-1:0]  load_lat,
  input  logic              wb,
  output logic              valid,
  output logic              regwrite,
  output logic [ADDR_W-1:0] vdst,
  output logic              valid_next
);

  slot_t state_reg;
  slot_t state_next;

  // Next-state: load, else clear on writeback/expiry, else count down
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next.valid    = 1'b1;
      state_next.regwrite = load_regwrite;
      state_next.vdst     = load_vdst;
      state_next.cnt      = load_lat;
    end else if (state_reg.valid) begin
      if (wb || (state_reg.cnt == LAT_W'(1))) begin
        // writeback and expiry landing together collapse into one clear
        state_next = '0;
      end else if (state_reg.cnt > LAT_W'(1)) begin
        state_next.cnt = state_reg.cnt - LAT_W'(1);
      end
    end
  end

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
    end else begin
      state_reg <= state_next;
    end
  end

  assign valid      = state_reg.valid;
  assign regwrite   = state_reg.valid & state_reg.regwrite;
  assign vdst       = state_reg.vdst;
  assign valid_next = state_next.valid;

endmodule

// File: rtl/simd_dest_scoreboard.sv
// Per-FU destination register scoreboard. Decodes issue and writeback
// onto NUM_FU slots, answers RAW queries for the decode instruction and
// publishes destination addresses, busy bitmap and a registered busy count.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- a writeback in cycle C
// frees its slot in C for both the RAW query and a new issue.
module simd_dest_scoreboard
  import simd_core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  simd_dest_scoreboard_if.slave bus
);

  logic [NUM_FU-1:0] issue_sel;      // one-hot decode of issue_fu
  logic [NUM_FU-1:0] wb_hit;         // writeback aimed at a valid slot
  logic [NUM_FU-1:0] bypass;         // slot treated as free this cycle
  logic [NUM_FU-1:0] load;           // slot accepts the issue at the edge
  logic [NUM_FU-1:0] slot_valid;
  logic [NUM_FU-1:0] slot_regwrite;
  logic [NUM_FU-1:0] valid_next;
  logic [NUM_FU-1:0] qry_hit;
  logic [ADDR_W-1:0] slot_vdst [NUM_FU];

  logic              in_range;
  logic              sel_busy;
  logic              ready;
  logic [CNT_W-1:0]  busy_cnt_reg;

  // Out-of-range FU indices select no slot and are refused outright
  assign in_range = (bus.issue_fu < FU_IDX_W'(NUM_FU));
  assign sel_busy = |(issue_sel & slot_valid & ~bypass);
  assign ready    = ~rst & bus.issue_valid & in_range & ~sel_busy;

  assign bus.issue_ready = ready;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
      assign issue_sel[gi] = (bus.issue_fu == FU_IDX_W'(gi));
      assign wb_hit[gi]    = bus.wb_valid & (bus.wb_fu == FU_IDX_W'(gi)) & slot_valid[gi];
`ifdef SCOREBOARD_BYPASS_EN
      assign bypass[gi]    = wb_hit[gi];
`else
      assign bypass[gi]    = 1'b0;
`endif
      assign load[gi]      = ready & issue_sel[gi];
      // register 0 is an ordinary register here: a match on it is a hazard
      assign qry_hit[gi]   = slot_regwrite[gi] & ~bypass[gi] &
                             ((slot_vdst[gi] == bus.qry_rs) | (slot_vdst[gi] == bus.qry_rt));

      scoreboard_slot u_slot (
        .clk          (clk),
        .rst          (rst),
        .load         (load[gi]),
        .load_regwrite(bus.issue_regwrite),
        .load_vdst    (bus.issue_vdst),
        .load_lat     (bus.issue_lat),
        .wb           (wb_hit[gi]),
        .valid        (slot_valid[gi]),
        .regwrite     (slot_regwrite[gi]),
        .vdst         (slot_vdst[gi]),
        .valid_next   (valid_next[gi])
      );
    end
  endgenerate

  // Pack slot destinations onto the flat bus, FU0 at the LSBs
  always_comb begin
    bus.fu_vdst_addr = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_vdst_addr[i*ADDR_W +: ADDR_W] = slot_vdst[i];
    end
  end

  // Busy count tracks the slot registers by counting their next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_reg <= '0;
    end else begin
      busy_cnt_reg <= popcount(valid_next);
    end
  end

  assign bus.fu_busy     = slot_valid;
  assign bus.fu_regwrite = slot_regwrite;
  assign bus.raw_hazard  = |qry_hit;
  assign bus.busy_cnt    = busy_cnt_reg;

endmodule

// File: tb/tb_simd_dest_scoreboard.sv
// Self-checking bench for simd_dest_scoreboard. Directed scenarios plus a
// randomized run checked against a model that tracks, per slot, the cycle
// number at which it becomes free again.
module tb_simd_dest_scoreboard;
  import simd_core_pkg::*;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_dest_scoreboard_if sb_if();

  simd_dest_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .bus(sb_if)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: absolute cycle counter and per-slot release cycle
  longint            now = 0;
  longint            free_at [NUM_FU];
  logic [ADDR_W-1:0] m_vdst  [NUM_FU];
  bit                m_rw    [NUM_FU];

  // stimulus currently applied
  bit s_iv, s_rw, s_wv;
  int s_fu, s_vd, s_lat, s_wf, s_rs, s_rt;

  function automatic bit m_busy(input int f);
    return free_at[f] > now;
  endfunction

  function automatic bit m_bypass(input int f);
    return BYP && s_wv && (s_wf == f) && m_busy(f);
  endfunction

  function automatic bit m_ready();
    if (rst || !s_iv || s_fu >= NUM_FU) return 1'b0;
    return !m_busy(s_fu) || m_bypass(s_fu);
  endfunction

  function automatic logic [NUM_FU-1:0] m_busy_vec();
    logic [NUM_FU-1:0] v;
    for (int f = 0; f < NUM_FU; f++) v[f] = m_busy(f);
    return v;
  endfunction

  function automatic logic [NUM_FU-1:0] m_rw_vec();
    logic [NUM_FU-1:0] v;
    for (int f = 0; f < NUM_FU; f++) v[f] = m_busy(f) && m_rw[f];
    return v;
  endfunction

  function automatic logic [NUM_FU*ADDR_W-1:0] m_vdst_vec();
    logic [NUM_FU*ADDR_W-1:0] v;
    v = '0;
    for (int f = 0; f < NUM_FU; f++)
      if (m_busy(f)) v[f*ADDR_W +: ADDR_W] = m_vdst[f];
    return v;
  endfunction

  function automatic bit m_raw();
    for (int f = 0; f < NUM_FU; f++)
      if (m_busy(f) && m_rw[f] && !m_bypass(f) &&
          (int'(m_vdst[f]) == s_rs || int'(m_vdst[f]) == s_rt)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int f = 0; f < NUM_FU; f++) c += int'(m_busy(f));
    return c;
  endfunction

  task automatic drive(input bit iv, input int fu, input int vd, input bit rw, input int lat,
                       input bit wv, input int wf, input int rs, input int rt);
    s_iv = iv; s_fu = fu; s_vd = vd % 32; s_rw = rw; s_lat = lat % 16;
    s_wv = wv; s_wf = wf; s_rs = rs % 32; s_rt = rt % 32;
    sb_if.issue_valid    = iv;
    sb_if.issue_fu       = FU_IDX_W'(fu);
    sb_if.issue_vdst     = ADDR_W'(s_vd);
    sb_if.issue_regwrite = rw;
    sb_if.issue_lat      = LAT_W'(s_lat);
    sb_if.wb_valid       = wv;
    sb_if.wb_fu          = FU_IDX_W'(wf);
    sb_if.qry_rs         = ADDR_W'(s_rs);
    sb_if.qry_rt         = ADDR_W'(s_rt);
  endtask

  task automatic idle(input int rs, input int rt);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, rs, rt);
  endtask

  // advance one clock edge and apply the scoreboard rules to the model
  task automatic tick();
    bit acc;
    longint n;
    acc = m_ready();
    n = now;
    @(posedge clk);
    if (rst) begin
      for (int f = 0; f < NUM_FU; f++) begin
        free_at[f] = 0; m_rw[f] = 1'b0; m_vdst[f] = '0;
      end
    end else begin
      if (s_wv && s_wf < NUM_FU && free_at[s_wf] > n) free_at[s_wf] = n + 1;
      if (acc) begin
        free_at[s_fu] = (s_lat == 0) ? NEVER : n + s_lat + 1;
        m_vdst[s_fu]  = ADDR_W'(s_vd);
        m_rw[s_fu]    = s_rw;
      end
    end
    now = n + 1;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 0, 3, 1'b1, 2, 1'b0, 0, 0, 0);
    @(negedge clk);
    if (sb_if.issue_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", sb_if.issue_ready); end
    vectors++;
    if (sb_if.fu_busy !== '0 || sb_if.fu_regwrite !== '0) begin miscompares++; $display("FAIL reset_busy: got %b/%b want 0", sb_if.fu_busy, sb_if.fu_regwrite); end
    vectors++;
    if (sb_if.busy_cnt !== '0 || sb_if.raw_hazard !== 1'b0 || sb_if.fu_vdst_addr !== '0) begin
      miscompares++; $display("FAIL reset_outs: cnt %0d raw %b vdst %h want 0", sb_if.busy_cnt, sb_if.raw_hazard, sb_if.fu_vdst_addr);
    end
    vectors++;
    idle(0, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    drive(1'b1, 2, 7, 1'b1, 3, 1'b0, 0, 7, 0);
    @(negedge clk);
    if (sb_if.issue_ready !== 1'b1) begin miscompares++; $display("FAIL lat_issue_ready: got %b want 1", sb_if.issue_ready); end
    vectors++;
    tick();
    for (int k = 1; k <= 4; k++) begin
      bit exp_busy;
      exp_busy = (k <= 3);
      drive(1'b1, 2, 11, 1'b1, 1, 1'b0, 0, 7, 0);
      @(negedge clk);
      if (sb_if.fu_busy[2] !== exp_busy || sb_if.raw_hazard !== exp_busy) begin
        miscompares++; $display("FAIL lat_busy k=%0d: busy %b raw %b want %b", k, sb_if.fu_busy[2], sb_if.raw_hazard, exp_busy);
      end
      vectors++;
      if (sb_if.issue_ready !== !exp_busy) begin
        miscompares++; $display("FAIL lat_reissue k=%0d: got %b want %b", k, sb_if.issue_ready, !exp_busy);
      end
      vectors++;
      tick();
    end
    idle(11, 0);
    @(negedge clk);
    if (sb_if.fu_vdst_addr[2*ADDR_W +: ADDR_W] !== 5'd11 || sb_if.fu_busy[2] !== 1'b1) begin
      miscompares++; $display("FAIL lat_reload: vdst %0d busy %b want 11/1", sb_if.fu_vdst_addr[2*ADDR_W +: ADDR_W], sb_if.fu_busy[2]);
    end
    vectors++;
    tick();
    @(negedge clk);
    if (sb_if.fu_busy[2] !== 1'b0 || sb_if.fu_vdst_addr !== '0) begin
      miscompares++; $display("FAIL lat_lat1_clear: busy %b vdst %h want 0", sb_if.fu_busy[2], sb_if.fu_vdst_addr);
    end
    vectors++;
    tick();
  endtask

  task automatic test_writeback();
    drive(1'b1, 5, 20, 1'b1, 0, 1'b0, 0, 20, 0);
    @(negedge clk);
    if (sb_if.issue_ready !== 1'b1) begin miscompares++; $display("FAIL wb_issue: got %b want 1", sb_if.issue_ready); end
    vectors++;
    tick();
    for (int k = 0; k < 5; k++) begin
      idle(20, 0);
      @(negedge clk);
      if (sb_if.fu_busy[5] !== 1'b1 || sb_if.raw_hazard !== 1'b1) begin
        miscompares++; $display("FAIL wb_hold k=%0d: busy %b raw %b want 1/1", k, sb_if.fu_busy[5], sb_if.raw_hazard);
      end
      vectors++;
      tick();
    end
    drive(1'b1, 5, 21, 1'b1, 2, 1'b1, 5, 20, 0);
    @(negedge clk);
    if (sb_if.issue_ready !== BYP || sb_if.raw_hazard !== !BYP || sb_if.fu_busy[5] !== 1'b1) begin
      miscompares++; $display("FAIL wb_cycle: ready %b raw %b busy %b want %b/%b/1", sb_if.issue_ready, sb_if.raw_hazard, sb_if.fu_busy[5], BYP, !BYP);
    end
    vectors++;
    tick();
    drive(1'b1, 5, 21, 1'b1, 2, 1'b0, 0, 20, 0);
    @(negedge clk);
    if (sb_if.fu_busy[5] !== BYP || sb_if.issue_ready !== !BYP || sb_if.raw_hazard !== 1'b0) begin
      miscompares++; $display("FAIL wb_after: busy %b ready %b raw %b want %b/%b/0", sb_if.fu_busy[5], sb_if.issue_ready, sb_if.raw_hazard, BYP, !BYP);
    end
    vectors++;
    if (sb_if.fu_vdst_addr[5*ADDR_W +: ADDR_W] !== (BYP ? 5'd21 : 5'd0)) begin
      miscompares++; $display("FAIL wb_vdst: got %0d want %0d", sb_if.fu_vdst_addr[5*ADDR_W +: ADDR_W], BYP ? 21 : 0);
    end
    vectors++;
    tick();
    idle(0, 0);
    repeat (3) tick();
  endtask

  task automatic test_busy_and_range();
    drive(1'b1, 4, 3, 1'b1, 4, 1'b0, 0, 0, 0);
    @(negedge clk);
    if (sb_if.issue_ready !== 1'b1) begin miscompares++; $display("FAIL busy_first: got %b want 1", sb_if.issue_ready); end
    vectors++;
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 4, 4, 1'b1, 1, 1'b0, 0, 0, 0);
      @(negedge clk);
      if (sb_if.issue_ready !== (k == 5)) begin
        miscompares++; $display("FAIL busy_block k=%0d: got %b want %b", k, sb_if.issue_ready, k == 5);
      end
      vectors++;
      tick();
    end
    idle(0, 0);
    repeat (2) tick();
    for (int fu = NUM_FU; fu < 16; fu++) begin
      drive(1'b1, fu, 1, 1'b1, 2, 1'b1, fu, 1, 1);
      @(negedge clk);
      if (sb_if.issue_ready !== 1'b0 || sb_if.busy_cnt !== 4'd0) begin
        miscompares++; $display("FAIL range fu=%0d: ready %b cnt %0d want 0/0", fu, sb_if.issue_ready, sb_if.busy_cnt);
      end
      vectors++;
      tick();
    end
    idle(0, 0);
    tick();
  endtask

  task automatic test_no_regwrite();
    drive(1'b1, 7, 9, 1'b0, 2, 1'b0, 0, 0, 9);
    @(negedge clk);
    if (sb_if.issue_ready !== 1'b1) begin miscompares++; $display("FAIL norw_issue: got %b want 1", sb_if.issue_ready); end
    vectors++;
    tick();
    idle(0, 9);
    @(negedge clk);
    if (sb_if.fu_busy[7] !== 1'b1 || sb_if.fu_regwrite[7] !== 1'b0 || sb_if.raw_hazard !== 1'b0) begin
      miscompares++; $display("FAIL norw: busy %b rw %b raw %b want 1/0/0", sb_if.fu_busy[7], sb_if.fu_regwrite[7], sb_if.raw_hazard);
    end
    vectors++;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    bit seen_wb;
    bit prev_wb;
    seen_wb = 1'b0;
    prev_wb = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      drive(1'b1, f, f + 1, 1'b1, 15, 1'b0, 0, 0, 0);
      @(negedge clk);
      if (sb_if.issue_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_issue fu=%0d: got %b want 1", f, sb_if.issue_ready); end
      vectors++;
      tick();
    end
    idle(0, 0);
    @(negedge clk);
    if (sb_if.busy_cnt !== 4'd11 || sb_if.fu_busy !== 11'h7ff) begin
      miscompares++; $display("FAIL b2b_full: cnt %0d busy %b want 11/all", sb_if.busy_cnt, sb_if.fu_busy);
    end
    vectors++;
    tick();
    for (int i = 0; i < 30; i++) begin
      bit wv;
      wv = (free_at[6] == now + 1);
      drive(1'b0, 0, 0, 1'b0, 0, wv, 6, 0, 0);
      @(negedge clk);
      if (wv && sb_if.busy_cnt !== 4'd5) begin
        miscompares++; $display("FAIL b2b_pre_wb: cnt %0d want 5", sb_if.busy_cnt);
      end
      if (prev_wb && sb_if.busy_cnt !== 4'd4) begin
        miscompares++; $display("FAIL b2b_wb_expiry: cnt %0d want 4", sb_if.busy_cnt);
      end
      if (wv || prev_wb) vectors++;
      if (int'(sb_if.busy_cnt) !== m_cnt()) begin
        miscompares++; $display("FAIL b2b_drain i=%0d: cnt %0d want %0d", i, sb_if.busy_cnt, m_cnt());
      end
      vectors++;
      if (wv) seen_wb = 1'b1;
      prev_wb = wv;
      tick();
    end
    if (!seen_wb) begin miscompares++; $display("FAIL b2b_no_wb_window: got 0 want 1"); end
    vectors++;
  endtask

  task automatic test_reset_midrun();
    drive(1'b1, 1, 5, 1'b1, 0, 1'b0, 0, 0, 0); tick();
    drive(1'b1, 3, 6, 1'b1, 0, 1'b0, 0, 0, 0); tick();
    drive(1'b1, 8, 7, 1'b1, 0, 1'b0, 0, 0, 0); tick();
    drive(1'b1, 0, 10, 1'b1, 2, 1'b0, 0, 5, 6);
    @(negedge clk);
    if (sb_if.busy_cnt !== 4'd3 || sb_if.raw_hazard !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_pre: cnt %0d raw %b want 3/1", sb_if.busy_cnt, sb_if.raw_hazard);
    end
    vectors++;
    #2 rst = 1'b1;
    #1;
    if (sb_if.fu_busy !== '0 || sb_if.busy_cnt !== '0 || sb_if.fu_vdst_addr !== '0) begin
      miscompares++; $display("FAIL rstmid_clear: busy %b cnt %0d vdst %h want 0", sb_if.fu_busy, sb_if.busy_cnt, sb_if.fu_vdst_addr);
    end
    vectors++;
    if (sb_if.issue_ready !== 1'b0 || sb_if.raw_hazard !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_ready: ready %b raw %b want 0/0", sb_if.issue_ready, sb_if.raw_hazard);
    end
    vectors++;
    tick();
    rst = 1'b0;
    idle(0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      @(negedge clk);
      if (sb_if.issue_ready !== m_ready()) begin
        miscompares++; $display("FAIL rand_ready i=%0d: got %b want %b", i, sb_if.issue_ready, m_ready());
      end
      vectors++;
      if (sb_if.fu_busy !== m_busy_vec() || sb_if.fu_regwrite !== m_rw_vec()) begin
        miscompares++; $display("FAIL rand_bitmaps i=%0d: busy %b rw %b want %b %b", i, sb_if.fu_busy, sb_if.fu_regwrite, m_busy_vec(), m_rw_vec());
      end
      vectors++;
      if (sb_if.fu_vdst_addr !== m_vdst_vec()) begin
        miscompares++; $display("FAIL rand_vdst i=%0d: got %h want %h", i, sb_if.fu_vdst_addr, m_vdst_vec());
      end
      vectors++;
      if (sb_if.raw_hazard !== m_raw() || int'(sb_if.busy_cnt) !== m_cnt()) begin
        miscompares++; $display("FAIL rand_raw_cnt i=%0d: raw %b cnt %0d want %b %0d", i, sb_if.raw_hazard, sb_if.busy_cnt, m_raw(), m_cnt());
      end
      vectors++;
      tick();
    end
    idle(0, 0);
  endtask

  initial begin
    for (int f = 0; f < NUM_FU; f++) begin
      free_at[f] = 0; m_rw[f] = 1'b0; m_vdst[f] = '0;
    end
    idle(0, 0);
    test_reset();
    test_latency();
    test_writeback();
    test_busy_and_range();
    test_no_regwrite();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
